// File: rtl/sub.sv
// WIDTH-bit subtractor with combinational flags, an enable-gated result/flag
// register and a saturating counter of enabled overflow cycles.
module sub #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] c,
    output logic             borrow,
    output logic             ovf,
    output logic             zero,
    output logic             neg,
    output logic [WIDTH-1:0] c_q,
    output logic [3:0]       flags_q,
    output logic [CNT_W-1:0] ovf_cnt
);

    logic [WIDTH:0] diff_ext;

    // One extra bit on the subtraction exposes the unsigned borrow directly.
    always_comb begin
        diff_ext = {1'b0, a} - {1'b0, b};
        c        = diff_ext[WIDTH-1:0];
        borrow   = diff_ext[WIDTH];
        ovf      = (a[WIDTH-1] != b[WIDTH-1]) && (c[WIDTH-1] != a[WIDTH-1]);
        zero     = (c == '0);
        neg      = c[WIDTH-1];
    end

    // Counter sticks at all-ones rather than wrapping back to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            c_q     <= '0;
            flags_q <= 4'b0000;
            ovf_cnt <= '0;
        end else if (en) begin
            c_q     <= c;
            flags_q <= {borrow, ovf, zero, neg};
            if (ovf && (ovf_cnt != {CNT_W{1'b1}}))
                ovf_cnt <= ovf_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_sub.sv
// Bench for sub: arithmetic reference model checked every negedge, plus
// hand-computed literal vectors for the key corner cases.
module tb_sub;

    logic        clk;
    logic        rst;
    logic        en;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] c;
    logic        borrow;
    logic        ovf;
    logic        zero;
    logic        neg;
    logic [15:0] c_q;
    logic [3:0]  flags_q;
    logic [7:0]  ovf_cnt;

    int testCount = 0;
    int failCount = 0;
    bit checking  = 0;

    logic [15:0] mCq;
    logic [3:0]  mFlags;
    int          mCnt;

    sub #(.WIDTH(16), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .en(en), .a(a), .b(b),
        .c(c), .borrow(borrow), .ovf(ovf), .zero(zero), .neg(neg),
        .c_q(c_q), .flags_q(flags_q), .ovf_cnt(ovf_cnt)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    // Reference difference and flags from plain integer arithmetic.
    function automatic void modelComb(input logic [15:0] x, input logic [15:0] y,
                                      output logic [15:0] d, output logic [3:0] f);
        int ua, ub, sa, sb, sd, ud;
        ua = int'(x);
        ub = int'(y);
        sa = int'($signed(x));
        sb = int'($signed(y));
        sd = sa - sb;
        ud = (ua - ub + 65536) % 65536;
        d  = ud[15:0];
        f[3] = (ua < ub);
        f[2] = (sd > 32767) || (sd < -32768);
        f[1] = (ud == 0);
        f[0] = (ud >= 32768);
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        testCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] x, input logic [15:0] y,
                                 input logic e, input logic r);
        a   = x;
        b   = y;
        en  = e;
        rst = r;
    endtask

    task automatic stepCycle();
        @(posedge clk);
        @(negedge clk);
        #2;
    endtask

    // Register model advanced on each rising edge from the sampled inputs.
    always @(posedge clk) begin
        logic [15:0] d;
        logic [3:0]  f;
        if (rst) begin
            mCq    = 16'd0;
            mFlags = 4'd0;
            mCnt   = 0;
        end else if (en) begin
            modelComb(a, b, d, f);
            mCq    = d;
            mFlags = f;
            if (f[2] && mCnt < 255)
                mCnt++;
        end
    end

    always @(negedge clk) begin
        logic [15:0] d;
        logic [3:0]  f;
        if (checking) begin
            modelComb(a, b, d, f);
            checkOutput("model c", int'(c), int'(d));
            checkOutput("model flags", int'({borrow, ovf, zero, neg}), int'(f));
            checkOutput("model c_q", int'(c_q), int'(mCq));
            checkOutput("model flags_q", int'(flags_q), int'(mFlags));
            checkOutput("model ovf_cnt", int'(ovf_cnt), mCnt);
        end
    end

    logic [15:0] vecA [8];
    logic [15:0] vecB [8];

    initial begin
        vecA = '{16'h0000, 16'h0000, 16'h8000, 16'h7FFF, 16'hFFFF, 16'h8000, 16'h7FFF, 16'h1234};
        vecB = '{16'h0000, 16'h0001, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h7FFF, 16'h8000, 16'h4321};

        applyStimulus(16'd0, 16'd0, 1'b0, 1'b1);
        stepCycle();
        stepCycle();
        checkOutput("reset c_q", int'(c_q), 0);
        checkOutput("reset flags_q", int'(flags_q), 0);
        checkOutput("reset ovf_cnt", int'(ovf_cnt), 0);

        applyStimulus(16'd10, 16'd5, 1'b0, 1'b1);
        #1;
        checkOutput("10-5 c", int'(c), 5);
        checkOutput("10-5 flags", int'({borrow, ovf, zero, neg}), 0);

        applyStimulus(16'd20, 16'd30, 1'b0, 1'b0);
        #1;
        checkOutput("20-30 c", int'(c), 65526);
        checkOutput("20-30 flags", int'({borrow, ovf, zero, neg}), 9);

        applyStimulus(16'd1000, 16'd999, 1'b0, 1'b0);
        #1;
        checkOutput("1000-999 c", int'(c), 1);
        checkOutput("1000-999 flags", int'({borrow, ovf, zero, neg}), 0);

        checking = 1;
        stepCycle();
        checkOutput("hold c_q", int'(c_q), 0);

        applyStimulus(16'd32768, 16'd1, 1'b1, 1'b0);
        #1;
        checkOutput("ovf c", int'(c), 32767);
        checkOutput("ovf comb flags", int'({borrow, ovf, zero, neg}), 4);
        stepCycle();
        checkOutput("ovf c_q", int'(c_q), 32767);
        checkOutput("ovf flags_q", int'(flags_q), 4);
        checkOutput("ovf ovf_cnt", int'(ovf_cnt), 1);

        applyStimulus(16'h1234, 16'h1234, 1'b1, 1'b0);
        stepCycle();
        checkOutput("eq c", int'(c), 0);
        checkOutput("eq c_q", int'(c_q), 0);
        checkOutput("eq flags_q", int'(flags_q), 2);
        applyStimulus(16'd7, 16'd2, 1'b0, 1'b0);
        #1;
        checkOutput("disabled c", int'(c), 5);
        checkOutput("disabled c_q", int'(c_q), 0);
        stepCycle();
        checkOutput("disabled c_q after edge", int'(c_q), 0);
        checkOutput("disabled flags_q after edge", int'(flags_q), 2);

        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecA[i], vecB[i], 1'b1, 1'b0);
            stepCycle();
            applyStimulus(vecB[i], vecA[i], 1'(i % 2), 1'b0);
            stepCycle();
        end

        applyStimulus(16'd32768, 16'd1, 1'b1, 1'b0);
        for (int i = 0; i < 300; i++)
            stepCycle();
        checkOutput("saturated ovf_cnt", int'(ovf_cnt), 255);

        applyStimulus(16'd32768, 16'd1, 1'b1, 1'b1);
        stepCycle();
        checkOutput("mid reset c_q", int'(c_q), 0);
        checkOutput("mid reset flags_q", int'(flags_q), 0);
        checkOutput("mid reset ovf_cnt", int'(ovf_cnt), 0);
        checkOutput("mid reset c", int'(c), 32767);

        applyStimulus(16'd32768, 16'd1, 1'b1, 1'b0);
        stepCycle();
        checkOutput("resume c_q", int'(c_q), 32767);
        checkOutput("resume ovf_cnt", int'(ovf_cnt), 1);

        checking = 0;
        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
